// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and sizing definitions for the sequential ALU.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_INC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2,
        S_DIV  = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath: W-step shift-add multiplier and, with ALU_DIV_EN,
// a restoring divider sharing the same accumulator and counter.
// done_c and result_c are combinational: they flag and carry the final step.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef ALU_DIV_EN
    input  logic              div,
`endif
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              done_c,
    output logic [2*W-1:0]    result_c
);

    localparam int unsigned CW = clog2(W);
    localparam int unsigned RW = 2 * W;

    logic          busy;
    logic [CW-1:0] cnt;
    logic [RW-1:0] acc;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [RW-1:0] mul_nxt;
    logic [RW-1:0] acc_nxt;

    assign mul_nxt = acc + (mplier[0] ? (RW'(mcand) << cnt) : '0);

`ifdef ALU_DIV_EN
    // Divide layout: acc[2W-1:W] is the partial remainder, acc[W-1:0] the
    // dividend being shifted out while quotient bits shift in.
    logic          div_q;
    logic [W:0]    rem_sh;
    logic [W:0]    trial;
    logic [RW-1:0] div_nxt;

    always_comb begin
        rem_sh  = acc[RW-1:W-1];
        trial   = rem_sh - {1'b0, mcand};
        div_nxt = '0;
        if (!trial[W]) div_nxt = {trial[W-1:0], acc[W-2:0], 1'b1};
        else           div_nxt = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end

    assign acc_nxt = div_q ? div_nxt : mul_nxt;
`else
    assign acc_nxt = mul_nxt;
`endif

    assign done_c   = busy && (cnt == CW'(W - 1));
    assign result_c = acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
`ifdef ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mplier <= b;
`ifdef ALU_DIV_EN
            div_q  <= div;
            acc    <= div ? RW'(a) : '0;
            mcand  <= div ? b : a;
`else
            acc    <= '0;
            mcand  <= a;
`endif
        end else if (busy) begin
            acc    <= acc_nxt;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done_c) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential add/sub/mul ALU with valid/ready handshakes on both sides.
// Optional macro ALU_DIV_EN adds an iterative unsigned divider on f=110.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   r,
    output logic             err
);

    localparam int unsigned RW = 2 * W;

    state_t        state;
    state_t        state_nxt;
    logic          accept_c;
    logic          is_mul_c;
    logic          is_div_c;
    logic          start_c;
    logic          done_c;
    logic [RW-1:0] iter_res_c;
    logic [W:0]    sum_c;
    logic [W:0]    inc_c;
    logic [W:0]    sub_c;
    logic [W:0]    dec_c;
    logic [RW-1:0] single_r_c;
    logic          single_err_c;

    assign accept_c = in_valid && (state == S_IDLE);
    assign is_mul_c = (f[2:1] == OP_MUL[2:1]);
`ifdef ALU_DIV_EN
    assign is_div_c = (f == OP_DIV);
`else
    assign is_div_c = 1'b0;
`endif
    assign start_c  = accept_c && (is_mul_c || is_div_c);

    alu_seq_iter #(.W(W)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (start_c),
`ifdef ALU_DIV_EN
        .div      (is_div_c),
`endif
        .a        (a),
        .b        (b),
        .done_c   (done_c),
        .result_c (iter_res_c)
    );

    // Single-cycle ops: sums zero-extend, differences sign-extend.
    assign sum_c = {1'b0, a} + {1'b0, b};
    assign inc_c = {1'b0, a} + (W + 1)'(1);
    assign sub_c = {1'b0, a} - {1'b0, b};
    assign dec_c = {1'b0, a} - (W + 1)'(1);

    always_comb begin
        single_r_c   = '0;
        single_err_c = 1'b0;
        case (f)
            OP_ADD:  single_r_c = RW'(sum_c);
            OP_INC:  single_r_c = RW'(inc_c);
            OP_SUB:  single_r_c = {{(RW - W - 1){sub_c[W]}}, sub_c};
            OP_DEC:  single_r_c = {{(RW - W - 1){dec_c[W]}}, dec_c};
            default: single_err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    if (is_mul_c)      state_nxt = S_MUL;
`ifdef ALU_DIV_EN
                    else if (is_div_c) state_nxt = S_DIV;
`endif
                    else               state_nxt = S_DONE;
                end
            end
            S_MUL:   if (done_c) state_nxt = S_DONE;
`ifdef ALU_DIV_EN
            S_DIV:   if (done_c) state_nxt = S_DONE;
`endif
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Result registers: loaded on accept for single-cycle ops, on the last
    // iteration for mul/div, and otherwise held through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r   <= '0;
            err <= 1'b0;
        end else if (accept_c) begin
            if (start_c) begin
                err <= is_div_c && (b == '0);
            end else begin
                r   <= single_r_c;
                err <= single_err_c;
            end
        end else if (done_c) begin
            r <= iter_res_c;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (W=4 main instance, W=8 multiply).
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] f;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] r;
    logic       err;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [2:0]  f8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] r8;
    logic        err8;

    int n_checks;
    int n_fail;

    alu_seq #(.W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .err(err)
    );

    alu_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .f(f8), .out_valid(out_valid8), .out_ready(out_ready8),
        .r(r8), .err(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle op with out_ready held high: result after one edge, idle after two.
    task automatic run_single(input string tag, input logic [2:0] op, input logic [3:0] va,
                              input logic [3:0] vb, input logic [7:0] exp_r, input logic exp_err);
        f = op; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".r"},         32'(r),         32'(exp_r));
        check({tag, ".err"},       32'(err),       32'(exp_err));
        tick();
        check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_back"},  32'(in_ready),  32'd1);
    endtask

    // Iterative op: out_valid exactly 4 edges after accept, then held for
    // hold cycles of backpressure while in_valid pulses are ignored.
    task automatic run_iter(input string tag, input logic [2:0] op, input logic [3:0] va,
                            input logic [3:0] vb, input logic [7:0] exp_r, input logic exp_err,
                            input int hold);
        f = op; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, ".busy_valid"}, 32'(out_valid), 32'd0);
            check({tag, ".busy_ready"}, 32'(in_ready),  32'd0);
            tick();
        end
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".r"},         32'(r),         32'(exp_r));
        check({tag, ".err"},       32'(err),       32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            a = 4'd1; b = 4'd1; f = 3'b000;
            tick();
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_r"},     32'(r),         32'(exp_r));
            check({tag, ".hold_ready"}, 32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_back"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; f = '0; out_ready = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; f8 = '0; out_ready8 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset.in_ready",  32'(in_ready),  32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.r",         32'(r),         32'd0);
        check("reset.err",       32'(err),       32'd0);

        run_single("add_9_8", 3'b000, 4'd9,  4'd8, 8'h11, 1'b0);
        run_single("sub_3_5", 3'b010, 4'd3,  4'd5, 8'hFE, 1'b0);
        run_single("dec_0",   3'b011, 4'd0,  4'd7, 8'hFF, 1'b0);
        run_single("inc_15",  3'b001, 4'd15, 4'd0, 8'h10, 1'b0);
        run_single("ill_111", 3'b111, 4'd5,  4'd3, 8'h00, 1'b1);
        run_single("add_clr", 3'b000, 4'd15, 4'd15, 8'h1E, 1'b0);

        run_iter("mul_15_15", 3'b100, 4'd15, 4'd15, 8'hE1, 1'b0, 0);
        run_iter("mul_7_6_bp", 3'b101, 4'd7, 4'd6, 8'h2A, 1'b0, 5);

`ifdef ALU_DIV_EN
        run_iter("div_13_4", 3'b110, 4'd13, 4'd4, 8'h13, 1'b0, 0);
        run_iter("div_13_0", 3'b110, 4'd13, 4'd0, 8'hDF, 1'b1, 0);
`else
        run_single("ill_110", 3'b110, 4'd13, 4'd4, 8'h00, 1'b1);
`endif

        // Abort a multiply with reset on its second iteration cycle.
        f = 3'b100; a = 4'd15; b = 4'd15; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.r",         32'(r),         32'd0);
        check("abort.err",       32'(err),       32'd0);
        check("abort.in_ready",  32'(in_ready),  32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort.no_emit", 32'(out_valid), 32'd0);
        end
        run_single("add_1_1", 3'b000, 4'd1, 4'd1, 8'h02, 1'b0);

        // Wide instance: 255*255 after 8 iterations.
        f8 = 3'b100; a8 = 8'd255; b8 = 8'd255; in_valid8 = 1'b1; out_ready8 = 1'b0;
        tick();
        in_valid8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("mul8.busy_valid", 32'(out_valid8), 32'd0);
            check("mul8.busy_ready", 32'(in_ready8),  32'd0);
            tick();
        end
        check("mul8.out_valid", 32'(out_valid8), 32'd1);
        check("mul8.r",         32'(r8),         32'h0000FE01);
        check("mul8.err",       32'(err8),       32'd0);
        out_ready8 = 1'b1;
        tick();
        check("mul8.out_valid_drop", 32'(out_valid8), 32'd0);
        check("mul8.in_ready_back",  32'(in_ready8),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
